cpu_trace: RTL

Parametrised on-chip trace buffer for the stack CPU pipeline; the synthesizable successor to the simulation-only per-cycle debug printout. It records a per-cycle snapshot of the writeback-side pipeline signals into a circular buffer of `DEPTH` entries. Recording stops a programmable number of records after a trigger (PC match, branch kill, or manual). The frozen history is then streamed out oldest-first over a valid/ready port to the debug host interface.

---
 rtl/cpu_trace.sv | 121 ++++++++++++
 1 files changed

// File: rtl/cpu_trace.sv
// On-chip trace buffer for the stack CPU writeback stage: circular capture with
// programmable post-trigger depth, then oldest-first valid/ready readout.
module cpu_trace #(
    parameter int DEPTH      = 16,
    parameter int TSW        = 16,
    parameter bit SKIP_STALL = 1'b1,
    localparam int AW        = $clog2(DEPTH),
    localparam int REC_W     = TSW + 70
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             kill_4a,
    input  logic             stall_2a,
    input  logic [31:0]      pc_4a,
    input  logic             st__push_5a,
    input  logic [34:0]      st__to_push_5a,
    input  logic             arm,
    input  logic [1:0]       trig_mode,
    input  logic [31:0]      trig_pc,
    input  logic             trig_force,
    input  logic [AW-1:0]    post_cnt,
    output logic [1:0]       state,
    output logic             rd_valid,
    output logic [REC_W-1:0] rd_data,
    output logic             rd_last,
    input  logic             rd_ready
);

    typedef enum logic [1:0] {IDLE, ARMED, POST, DONE} state_e;

    typedef struct packed {
        logic [TSW-1:0] ts;
        logic           kill;
        logic           stall;
        logic           push;
        logic [31:0]    pc;
        logic [34:0]    to_push;
    } rec_t;

    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    state_e         st;
    logic [TSW-1:0] ts;
    logic [AW-1:0]  wr_ptr, rd_ptr, rd_start, post_rem;
    logic [AW:0]    fill, rd_rem;
    rec_t           mem [DEPTH];
    rec_t           wr_rec;
    logic           recordable, we, hit;

    assign state      = st;
    assign recordable = (st == ARMED || st == POST) && !(SKIP_STALL && stall_2a);
    // arm takes priority: the arming cycle itself is never captured
    assign we         = recordable && !arm;
    assign hit        = trig_force || (trig_mode[0] && pc_4a == trig_pc) || (trig_mode[1] && kill_4a);
    assign wr_rec     = {ts, kill_4a, stall_2a, st__push_5a, pc_4a, st__to_push_5a};
    assign rd_start   = wr_ptr - fill[AW-1:0];

    always_ff @(posedge clk) begin
        if (we) mem[wr_ptr] <= wr_rec;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st       <= IDLE;
            ts       <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fill     <= '0;
            rd_rem   <= '0;
            post_rem <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
            rd_last  <= 1'b0;
        end else begin
            ts <= ts + TSW'(1);
            if (arm) begin
                st       <= ARMED;
                wr_ptr   <= '0;
                fill     <= '0;
                post_rem <= post_cnt;
                rd_valid <= 1'b0;
                rd_last  <= 1'b0;
            end else begin
                if (we) begin
                    wr_ptr <= wr_ptr + AW'(1);
                    if (fill != FULL) fill <= fill + (AW+1)'(1);
                end
                case (st)
                    ARMED: if (we && hit) st <= (post_rem == '0) ? DONE : POST;
                    POST: if (we) begin
                        post_rem <= post_rem - AW'(1);
                        if (post_rem == AW'(1)) st <= DONE;
                    end
                    DONE: begin
                        // first DONE cycle prefetches the oldest record
                        if (!rd_valid) begin
                            rd_data  <= mem[rd_start];
                            rd_ptr   <= rd_start + AW'(1);
                            rd_rem   <= fill - (AW+1)'(1);
                            rd_last  <= (fill == (AW+1)'(1));
                            rd_valid <= 1'b1;
                        end else if (rd_ready) begin
                            if (rd_last) begin
                                st       <= IDLE;
                                rd_valid <= 1'b0;
                                rd_last  <= 1'b0;
                            end else begin
                                rd_data <= mem[rd_ptr];
                                rd_ptr  <= rd_ptr + AW'(1);
                                rd_rem  <= rd_rem - (AW+1)'(1);
                                rd_last <= (rd_rem == (AW+1)'(1));
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
